// File: rtl/cid_pkg.sv
// Shared types and the round/shift/saturate helper for the integrate-and-dump stage.
// Samples are Q2.16 signed. The helper works on a wide signed value so that any accumulator width fits.
package cid_pkg;

  localparam int DATA_W = 18;
  localparam int FRAC_W = 16;
  localparam int MAX_W  = 64;

  typedef enum logic {IDLE, ACCUM} state_t;

  typedef struct packed {
    logic                    clip;
    logic signed [MAX_W-1:0] value;
  } rs_t;

  // Add half an LSB, arithmetic shift right, then clamp to a signed field of 'width' bits.
  function automatic rs_t sat_round(input logic signed [MAX_W-1:0] sum,
                                    input int shift, input int width);
    rs_t res;
    logic signed [MAX_W-1:0] one;
    logic signed [MAX_W-1:0] r;
    logic signed [MAX_W-1:0] max_v;
    logic signed [MAX_W-1:0] min_v;
    one = {{(MAX_W-1){1'b0}}, 1'b1};
    r = sum;
    if (shift > 0) begin
      r = (sum + (one <<< (shift - 1))) >>> shift;
    end
    max_v = (one <<< (width - 1)) - one;
    min_v = -(one <<< (width - 1));
    res.clip  = 1'b0;
    res.value = r;
    if (r > max_v) begin
      res.clip  = 1'b1;
      res.value = max_v;
    end else if (r < min_v) begin
      res.clip  = 1'b1;
      res.value = min_v;
    end
    return res;
  endfunction

endpackage

// File: rtl/cid_round_sat.sv
// Combinational round-half-up shift and saturation for one rail (I or Q).
module cid_round_sat
  import cid_pkg::*;
#(
  parameter int ACC_W = 26,
  parameter int OUT_W = 18,
  parameter int SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic signed [OUT_W-1:0] value,
  output logic                    clip
);

  logic signed [MAX_W-1:0] sum_ext;
  rs_t                     rs;
  logic                    unused_hi;

  always_comb begin
    sum_ext = {{(MAX_W-ACC_W){sum[ACC_W-1]}}, sum};
    rs      = sat_round(sum_ext, SHIFT, OUT_W);
    value   = rs.value[OUT_W-1:0];
    clip    = rs.clip;
  end

  // After clamping the upper bits are pure sign copies.
  assign unused_hi = ^rs.value[MAX_W-1:OUT_W];

endmodule

// File: rtl/cplx_integrate_dump.sv
// Coherent I/Q integrate-and-dump: sums LEN accepted samples, emits one rounded,
// saturated result per frame on a valid/ready output that holds until taken.
module cplx_integrate_dump #(
  parameter int DATA_W = 18,
  parameter int LEN_W  = 8,
  parameter int SHIFT  = 0
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic signed [DATA_W-1:0] data_i_i,
  input  logic signed [DATA_W-1:0] data_q_i,
  input  logic                     data_valid_i,
  output logic                     data_ready_o,
  input  logic [LEN_W-1:0]         len_i,
  output logic signed [DATA_W-1:0] data_i_o,
  output logic signed [DATA_W-1:0] data_q_o,
  output logic                     data_valid_o,
  input  logic                     data_ready_i,
  output logic                     sat_o
);

  import cid_pkg::*;

  localparam int ACC_W = DATA_W + LEN_W;
  localparam int CNT_W = LEN_W + 1;

  state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] len_reg, len_next;
  logic [CNT_W-1:0] len_eff, frame_len;

  logic signed [DATA_W-1:0] smp      [2];
  logic signed [ACC_W-1:0]  acc_reg  [2];
  logic signed [ACC_W-1:0]  acc_next [2];
  logic signed [ACC_W-1:0]  sum      [2];
  logic signed [DATA_W-1:0] rnd      [2];
  logic                     clip     [2];
  logic signed [DATA_W-1:0] out_reg  [2];
  logic signed [DATA_W-1:0] out_next [2];

  logic valid_reg, valid_next;
  logic sat_reg, sat_next;
  logic last, accept, dump;

  assign smp[0] = data_i_i;
  assign smp[1] = data_q_i;

  // The accumulator is zero whenever the FSM is idle, so acc + sample is also the first-sample value.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rail
      assign sum[gi] = acc_reg[gi] + {{LEN_W{smp[gi][DATA_W-1]}}, smp[gi]};

      cid_round_sat #(
        .ACC_W (ACC_W),
        .OUT_W (DATA_W),
        .SHIFT (SHIFT)
      ) u_round_sat (
        .sum   (sum[gi]),
        .value (rnd[gi]),
        .clip  (clip[gi])
      );
    end
  endgenerate

  always_comb begin
    len_eff = {1'b0, len_i};
    if (len_i == '0) begin
      len_eff = {1'b1, {LEN_W{1'b0}}};
    end
    frame_len = (state_reg == IDLE) ? len_eff : len_reg;
    last      = (cnt_reg + CNT_W'(1)) == frame_len;

    // Only a frame-completing sample can be stalled, and only while the output slot is blocked.
    data_ready_o = !(last && valid_reg && !data_ready_i);
    accept       = data_valid_i && data_ready_o;
    dump         = accept && last;

    state_next = state_reg;
    cnt_next   = cnt_reg;
    len_next   = len_reg;
    acc_next   = acc_reg;
    out_next   = out_reg;
    valid_next = valid_reg;
    sat_next   = sat_reg;

    if (accept) begin
      if (last) begin
        for (int r = 0; r < 2; r++) begin
          acc_next[r] = '0;
        end
        cnt_next   = '0;
        state_next = IDLE;
      end else begin
        acc_next   = sum;
        cnt_next   = cnt_reg + CNT_W'(1);
        state_next = ACCUM;
        if (state_reg == IDLE) begin
          len_next = len_eff;
        end
      end
    end

    if (dump) begin
      out_next   = rnd;
      sat_next   = clip[0] | clip[1];
      valid_next = 1'b1;
    end else if (valid_reg && data_ready_i) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      len_reg   <= '0;
      valid_reg <= 1'b0;
      sat_reg   <= 1'b0;
      for (int r = 0; r < 2; r++) begin
        acc_reg[r] <= '0;
        out_reg[r] <= '0;
      end
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      len_reg   <= len_next;
      valid_reg <= valid_next;
      sat_reg   <= sat_next;
      acc_reg   <= acc_next;
      out_reg   <= out_next;
    end
  end

  assign data_i_o     = out_reg[0];
  assign data_q_o     = out_reg[1];
  assign data_valid_o = valid_reg;
  assign sat_o        = sat_reg;

endmodule

// File: tb/tb_cplx_integrate_dump.sv
// Drives two instances (SHIFT=0 and SHIFT=2) with shared directed and random stimulus and
// compares every cycle against a frame-level reference model.
module tb_cplx_integrate_dump;

  localparam int DW = 18;
  localparam int LW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 srst;
  logic signed [DW-1:0] in_i, in_q;
  logic                 in_valid;
  logic [LW-1:0]        len;
  logic                 out_ready;

  logic                 rdy0, rdy2, ov0, ov2, sat0, sat2;
  logic signed [DW-1:0] oi0, oq0, oi2, oq2;

  cplx_integrate_dump #(.DATA_W(DW), .LEN_W(LW), .SHIFT(0)) dut_s0 (
    .clk_i(clk), .srst_i(srst), .data_i_i(in_i), .data_q_i(in_q),
    .data_valid_i(in_valid), .data_ready_o(rdy0), .len_i(len),
    .data_i_o(oi0), .data_q_o(oq0), .data_valid_o(ov0),
    .data_ready_i(out_ready), .sat_o(sat0)
  );

  cplx_integrate_dump #(.DATA_W(DW), .LEN_W(LW), .SHIFT(2)) dut_s2 (
    .clk_i(clk), .srst_i(srst), .data_i_i(in_i), .data_q_i(in_q),
    .data_valid_i(in_valid), .data_ready_o(rdy2), .len_i(len),
    .data_i_o(oi2), .data_q_o(oq2), .data_valid_o(ov2),
    .data_ready_i(out_ready), .sat_o(sat2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the samples of the open frame and the value held on each output.
  longint frame_i[$];
  longint frame_q[$];
  int     frame_len = 0;
  bit     m_valid = 1'b0;
  longint m_i[2] = '{0, 0};
  longint m_q[2] = '{0, 0};
  bit     m_sat[2] = '{1'b0, 1'b0};
  int     shifts[2] = '{0, 2};

  task automatic check_val(string tag, logic signed [63:0] got, logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int eff_len(int l);
    return (l == 0) ? 256 : l;
  endfunction

  function automatic longint round_sat(longint s, int sh, output bit clipped);
    longint r;
    r = s;
    if (sh > 0) r = (s + (longint'(1) << (sh - 1))) >>> sh;
    clipped = 1'b0;
    if (r > 131071) begin
      r = 131071;
      clipped = 1'b1;
    end else if (r < -131072) begin
      r = -131072;
      clipped = 1'b1;
    end
    return r;
  endfunction

  function automatic longint rand_smp();
    logic signed [DW-1:0] r;
    case ($urandom_range(0, 5))
      0:       r = {1'b0, {(DW-1){1'b1}}};
      1:       r = {1'b1, {(DW-1){1'b0}}};
      default: r = DW'($urandom);
    endcase
    return longint'(r);
  endfunction

  // One clock cycle: apply inputs, check outputs against the model, then advance the model.
  task automatic step(bit rst, bit v, longint di, longint dq, int l, bit rdy);
    int     exp_len;
    bit     exp_last, exp_rdy, dumped, ci, cq;
    longint si, sq;
    @(negedge clk);
    srst      = rst;
    in_valid  = v;
    in_i      = di[DW-1:0];
    in_q      = dq[DW-1:0];
    len       = l[LW-1:0];
    out_ready = rdy;
    #1;
    if (rst) begin
      frame_i.delete();
      frame_q.delete();
      m_valid = 1'b0;
      for (int s = 0; s < 2; s++) begin
        m_i[s] = 0;
        m_q[s] = 0;
        m_sat[s] = 1'b0;
      end
    end else begin
      exp_len  = (frame_i.size() == 0) ? eff_len(l) : frame_len;
      exp_last = (frame_i.size() + 1 == exp_len);
      exp_rdy  = !(exp_last && m_valid && !rdy);
      check_val("ready_s0", rdy0, exp_rdy);
      check_val("ready_s2", rdy2, exp_rdy);
      check_val("valid_s0", ov0, m_valid);
      check_val("valid_s2", ov2, m_valid);
      check_val("i_s0", oi0, m_i[0]);
      check_val("q_s0", oq0, m_q[0]);
      check_val("sat_s0", sat0, m_sat[0]);
      check_val("i_s2", oi2, m_i[1]);
      check_val("q_s2", oq2, m_q[1]);
      check_val("sat_s2", sat2, m_sat[1]);
      if (m_valid && rdy)
        $display("xfer s0 i=%0d q=%0d sat=%0b | s2 i=%0d q=%0d sat=%0b",
                 oi0, oq0, sat0, oi2, oq2, sat2);

      dumped = 1'b0;
      if (v && exp_rdy) begin
        if (frame_i.size() == 0) frame_len = exp_len;
        frame_i.push_back(di);
        frame_q.push_back(dq);
        if (frame_i.size() == frame_len) begin
          si = 0;
          sq = 0;
          foreach (frame_i[k]) begin
            si += frame_i[k];
            sq += frame_q[k];
          end
          for (int s = 0; s < 2; s++) begin
            m_i[s]   = round_sat(si, shifts[s], ci);
            m_q[s]   = round_sat(sq, shifts[s], cq);
            m_sat[s] = ci | cq;
          end
          m_valid = 1'b1;
          dumped  = 1'b1;
          frame_i.delete();
          frame_q.delete();
        end
      end
      if (!dumped && m_valid && rdy) m_valid = 1'b0;
    end
  endtask

  task automatic idle(int n, int l);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, 0, l, 1'b1);
  endtask

  longint quarter;
  longint ri[4], rq[4];

  initial begin
    quarter = longint'(1) << (cid_pkg::FRAC_W - 2);
    srst = 1'b1; in_valid = 1'b0; in_i = '0; in_q = '0; len = '0; out_ready = 1'b1;
    step(1'b1, 1'b0, 0, 0, 4, 1'b1);
    step(1'b1, 1'b0, 0, 0, 4, 1'b1);

    // Basic frame: four quarter-scale samples
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, quarter, -quarter, 4, 1'b1);
    idle(3, 4);

    // Saturation on both rails
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 131071, -131072, 4, 1'b1);
    idle(2, 4);

    // Rounding behaviour, visible on the SHIFT=2 instance
    ri = '{1, 1, 1, 0};
    rq = '{-1, -1, -1, 0};
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, ri[k], rq[k], 4, 1'b1);
    ri = '{-1, -1, 0, 0};
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, ri[k], 0, 4, 1'b1);
    idle(2, 4);

    // Backpressure with two-sample frames
    step(1'b0, 1'b1, 100, 200, 2, 1'b1);
    step(1'b0, 1'b1, 300, 400, 2, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 7 + k, -5, 2, 1'b0);
    step(1'b0, 1'b1, 50, 60, 2, 1'b1);
    idle(3, 2);

    // Length 1 pass-through, then length 0 meaning 256 samples
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, rand_smp(), rand_smp(), 1, 1'b1);
    idle(2, 1);
    for (int k = 0; k < 256; k++) step(1'b0, 1'b1, 131071, 3, 0, 1'b1);
    idle(3, 0);

    // Reset in the middle of a frame
    step(1'b0, 1'b1, 1000, 1000, 4, 1'b1);
    step(1'b0, 1'b1, 1000, 1000, 4, 1'b1);
    step(1'b1, 1'b1, 1000, 1000, 4, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1, 1, 4, 1'b1);
    idle(3, 4);

    // Random traffic: mid-frame length changes, backpressure, occasional resets
    for (int k = 0; k < 4000; k++) begin
      int l;
      l = ($urandom_range(0, 39) == 0) ? 0 : int'($urandom_range(1, 6));
      step(($urandom_range(0, 599) == 0), ($urandom_range(0, 9) < 7),
           rand_smp(), rand_smp(), l, ($urandom_range(0, 9) < 6));
    end
    idle(4, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
